// File: rtl/nor_chain_pipe.sv
// nor_chain_pipe: pipelined chain of two-input NOR/NAND gates across
// WIDTH independent lanes, one register stage per gate, valid/ready at
// both ends and a saturating count of results taken downstream.
//
// Each stage register carries its valid bit, the transaction mode, every
// tap computed so far and the side operands not yet consumed. Side
// operands are shifted right by one slice per stage, so the operand a
// stage needs is always in the low slice of its predecessor's register.
module nor_chain_pipe #(
  parameter int STAGES = 3,
  parameter int WIDTH  = 1,
  parameter int CNT_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_mode,
  input  logic [WIDTH-1:0]          in_a,
  input  logic [STAGES*WIDTH-1:0]   in_b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [STAGES*WIDTH-1:0]   out_taps,
  output logic                      out_mode,
  output logic [CNT_W-1:0]          done_cnt
);

  localparam int TW = STAGES * WIDTH;

  logic            r_valid [STAGES];
  logic            r_mode  [STAGES];
  logic [TW-1:0]   r_taps  [STAGES];
  logic [TW-1:0]   r_b     [STAGES];
  logic [CNT_W-1:0] r_cnt;

  logic            w_valid_nxt [STAGES];
  logic            w_mode_nxt  [STAGES];
  logic [TW-1:0]   w_taps_nxt  [STAGES];
  logic [TW-1:0]   w_b_nxt     [STAGES];
  logic            w_advance;
  logic            w_emit;
  logic            w_unused_b;

  // One gate of the chain: mode 0 is NOR, mode 1 is NAND, bitwise per lane.
  function automatic logic [WIDTH-1:0] gate(input logic mode,
                                            input logic [WIDTH-1:0] x,
                                            input logic [WIDTH-1:0] y);
    return mode ? ~(x & y) : ~(x | y);
  endfunction

  // The whole pipe moves together: it advances whenever the output slot is
  // empty or being drained, bubbles included.
  assign w_advance = ~r_valid[STAGES-1] | out_ready;
  assign w_emit    = r_valid[STAGES-1] & out_ready;
  assign in_ready  = w_advance;

  assign out_valid = r_valid[STAGES-1];
  assign out_taps  = r_taps[STAGES-1];
  assign out_mode  = r_mode[STAGES-1];
  assign done_cnt  = r_cnt;

  // The last stage has no side operands left to consume.
  assign w_unused_b = ^r_b[STAGES-1];

  // Next contents of every stage: copy the predecessor, add one tap.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      w_valid_nxt[k] = 1'b0;
      w_mode_nxt[k]  = 1'b0;
      w_taps_nxt[k]  = '0;
      w_b_nxt[k]     = '0;
    end

    w_valid_nxt[0]             = in_valid & in_ready;
    w_mode_nxt[0]              = in_mode;
    w_taps_nxt[0][0 +: WIDTH]  = gate(in_mode, in_a, in_b[0 +: WIDTH]);
    w_b_nxt[0]                 = in_b >> WIDTH;

    for (int k = 1; k < STAGES; k++) begin
      w_valid_nxt[k] = r_valid[k-1];
      w_mode_nxt[k]  = r_mode[k-1];
      w_taps_nxt[k]  = r_taps[k-1];
      w_taps_nxt[k][k*WIDTH +: WIDTH] = gate(r_mode[k-1],
                                             r_taps[k-1][(k-1)*WIDTH +: WIDTH],
                                             r_b[k-1][WIDTH-1:0]);
      w_b_nxt[k]     = r_b[k-1] >> WIDTH;
    end
  end

  // Stage registers: cleared on reset, loaded together on advance, else held.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        r_valid[k] <= 1'b0;
        r_mode[k]  <= 1'b0;
        r_taps[k]  <= '0;
        r_b[k]     <= '0;
      end
    end else if (w_advance) begin
      for (int k = 0; k < STAGES; k++) begin
        r_valid[k] <= w_valid_nxt[k];
        r_mode[k]  <= w_mode_nxt[k];
        r_taps[k]  <= w_taps_nxt[k];
        r_b[k]     <= w_b_nxt[k];
      end
    end
  end

  // Completed-result counter, sticks at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_emit && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_nor_chain_pipe.sv
// Bench for nor_chain_pipe: a main instance (8-bit counter) and a second
// instance with a 2-bit counter share the same stimulus. Expected results
// come from a queue-free slot model where each accepted item carries its
// complete gate-chain result, computed at entry from the chain formula.
module tb_nor_chain_pipe;
  localparam int S = 3;
  localparam int W = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, in_valid, in_mode, out_ready;
  logic [W-1:0]   in_a;
  logic [S*W-1:0] in_b;

  logic           in_ready, out_valid, out_mode;
  logic [S*W-1:0] out_taps;
  logic [7:0]     done_cnt;

  logic           sat_in_ready, sat_out_valid, sat_out_mode;
  logic [S*W-1:0] sat_out_taps;
  logic [1:0]     sat_done_cnt;

  int errors = 0;
  int checks = 0;

  // Model: one slot per stage holding the finished result of its item.
  bit           m_v    [S];
  bit [S*W-1:0] m_taps [S];
  bit           m_mode [S];
  int           m_cnt8 = 0;
  int           m_cnt2 = 0;

  logic [S*W-1:0] prev_taps;
  bit             hold;

  nor_chain_pipe #(.STAGES(S), .WIDTH(W), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_a(in_a), .in_b(in_b), .out_valid(out_valid),
    .out_ready(out_ready), .out_taps(out_taps), .out_mode(out_mode),
    .done_cnt(done_cnt));

  nor_chain_pipe #(.STAGES(S), .WIDTH(W), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(sat_in_ready),
    .in_mode(in_mode), .in_a(in_a), .in_b(in_b), .out_valid(sat_out_valid),
    .out_ready(out_ready), .out_taps(sat_out_taps), .out_mode(sat_out_mode),
    .done_cnt(sat_done_cnt));

  // Chain s[i] = ~(s[i-1] op b[i]), s[-1] = a.
  function automatic bit [S*W-1:0] golden(bit [W-1:0] a, bit [S*W-1:0] b, bit mode);
    bit [W-1:0]   s;
    bit [S*W-1:0] t;
    s = a;
    t = '0;
    for (int i = 0; i < S; i++) begin
      s = mode ? ~(s & b[i*W +: W]) : ~(s | b[i*W +: W]);
      t[i*W +: W] = s;
    end
    return t;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check in_ready, update the model, take the edge, check outputs.
  task automatic tick();
    bit adv, emit;
    #1;
    adv  = !m_v[S-1] || out_ready;
    emit = m_v[S-1] && out_ready;
    chk("in_ready", in_ready, adv);
    chk("sat_in_ready", sat_in_ready, adv);
    if (rst) begin
      for (int k = 0; k < S; k++) begin
        m_v[k] = 1'b0; m_taps[k] = '0; m_mode[k] = 1'b0;
      end
      m_cnt8 = 0;
      m_cnt2 = 0;
    end else begin
      if (emit) begin
        m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
        m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
      end
      if (adv) begin
        for (int k = S-1; k > 0; k--) begin
          m_v[k] = m_v[k-1]; m_taps[k] = m_taps[k-1]; m_mode[k] = m_mode[k-1];
        end
        m_v[0]    = in_valid;
        m_taps[0] = golden(in_a, in_b, in_mode);
        m_mode[0] = in_mode;
      end
    end
    @(posedge clk);
    #1;
    chk("out_valid", out_valid, m_v[S-1]);
    chk("sat_out_valid", sat_out_valid, m_v[S-1]);
    if (m_v[S-1]) begin
      chk("out_taps", out_taps, m_taps[S-1]);
      chk("out_mode", out_mode, m_mode[S-1]);
      chk("sat_out_taps", sat_out_taps, m_taps[S-1]);
    end
    chk("done_cnt", done_cnt, m_cnt8);
    chk("sat_done_cnt", sat_done_cnt, m_cnt2);
  endtask

  task automatic drive_random();
    in_a    = W'($urandom);
    in_b    = (S*W)'($urandom);
    in_mode = 1'($urandom);
  endtask

  // Single item with hand-derived taps; output must be high exactly one cycle.
  task automatic run_one(input bit [W-1:0] a, input bit [S*W-1:0] b, input bit mode,
                         input bit [S*W-1:0] exp_taps, input bit exp_mode, input string tag);
    in_valid = 1'b1; in_a = a; in_b = b; in_mode = mode;
    tick();
    in_valid = 1'b0;
    drive_random();
    tick();
    chk({tag, "_early"}, out_valid, 1'b0);
    tick();
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_taps"}, out_taps, exp_taps);
    chk({tag, "_mode"}, out_mode, exp_mode);
    tick();
    chk({tag, "_once"}, out_valid, 1'b0);
  endtask

  initial begin
    for (int k = 0; k < S; k++) begin
      m_v[k] = 1'b0; m_taps[k] = '0; m_mode[k] = 1'b0;
    end
    rst = 1'b1; in_valid = 1'b1; in_mode = 1'b0; in_a = '1; in_b = '1; out_ready = 1'b1;

    // Reset held two cycles with in_valid high
    tick();
    tick();
    chk("rst_taps", out_taps, '0);
    chk("rst_mode", out_mode, 1'b0);
    chk("rst_cnt", done_cnt, 8'd0);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    chk("idle_cnt", done_cnt, 8'd0);

    // Directed vectors
    run_one(1'b0, 3'b000, 1'b0, 3'b101, 1'b0, "nor1");
    chk("nor1_cnt", done_cnt, 8'd1);
    run_one(1'b1, 3'b010, 1'b0, 3'b100, 1'b0, "nor2");
    run_one(1'b1, 3'b111, 1'b1, 3'b010, 1'b1, "nand");

    // Back-to-back streaming of 8 random items
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      drive_random();
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("stream_cnt", done_cnt, 8'd8);
    chk("stream_sat_cnt", sat_done_cnt, 2'd3);

    // Backpressure: out_ready pattern 1,0,0,1 with random input gaps
    for (int i = 0; i < 40; i++) begin
      out_ready = ((i % 4) == 0) || ((i % 4) == 3);
      in_valid  = ($urandom_range(0, 3) != 0);
      drive_random();
      #1;
      hold      = out_valid && !out_ready;
      prev_taps = out_taps;
      tick();
      if (hold) chk("stall_hold", out_taps, prev_taps);
    end
    out_ready = 1'b1; in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    // Mid-flight reset discards two in-flight items
    rst = 1'b1; tick(); rst = 1'b0;
    in_valid = 1'b1;
    drive_random(); tick();
    drive_random(); tick();
    in_valid = 1'b0;
    rst = 1'b1; tick();
    chk("flush_valid", out_valid, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("flush_cnt", done_cnt, 8'd0);

    // Saturation of the 2-bit counter after five results
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      drive_random();
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("sat_cnt", sat_done_cnt, 2'd3);
    chk("sat_main_cnt", done_cnt, 8'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/nor_chain_pipe.md
Name: nor_chain_pipe

Overview:
Parametrised, pipelined successor to the three-gate cascaded NOR chain. It evaluates a chain of STAGES two-input gates, s[i] = ~(s[i-1] op b[i]) with s[-1] = a, across WIDTH independent bit lanes. There is one register stage per gate, a valid/ready handshake at each end, and a per-transaction NOR/NAND mode. It sits in the week-level logic labs as the reusable, clocked replacement for hand-wired gate cascades, and exposes every intermediate tap.

Parameters:
STAGES, 3, number of chained gates (>=1); equals pipeline depth
WIDTH, 1, independent bitwise lanes per operand (>=1)
CNT_W, 8, width of completed-result counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
in_valid  input  1  input transaction present
in_ready  output  1  block accepts input this cycle
in_mode  input  1  0 = NOR chain, 1 = NAND chain; captured per transaction
in_a  input  WIDTH  chain head operand
in_b  input  STAGES*WIDTH  side operand per stage; slice i = bits [i*WIDTH +: WIDTH]
out_valid  output  1  result present
out_ready  input  1  downstream accepts result
out_taps  output  STAGES*WIDTH  all stage results; slice i = s[i]; last slice = chain output
out_mode  output  1  mode of the presented result
done_cnt  output  CNT_W  count of results accepted downstream, saturating

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. Everything updates on the clk rising edge only.
- Reset (rst=1 at an edge): all stage valid bits 0, out_valid 0, out_taps 0, out_mode 0, done_cnt 0. Reset overrides any handshake in flight; items in the pipe are discarded, with no partial output.
- Stage k register (k=0..STAGES-1) holds:
  - valid_k and mode_k
  - taps s[0..k], computed
  - the unconsumed side operands b[k+1..STAGES-1], carried forward so that late operands stay aligned with their transaction.
- Stage 0 computes s[0] = ~(in_a op in_b[0]). Stage k computes s[k] = ~(s[k-1] op b[k]) from the stage k-1 register.
- op is | when mode=0 and & when mode=1. This is bitwise per lane; lanes never interact.
- Output register = stage STAGES-1. out_valid = valid_(STAGES-1). out_taps and out_mode come from that register.
- Stall rule (global):
  - advance = ~out_valid | out_ready
  - in_ready = advance (combinational, no dependency on in_valid)
  - When advance=1, every stage loads from its predecessor, and stage 0 loads valid = in_valid & in_ready.
  - When advance=0, all stages hold, including bubbles.
- Latency: an input accepted at edge n appears with out_valid=1 after edge n+STAGES-1, i.e. STAGES cycles after acceptance is visible. Throughput is 1 per cycle when out_ready is held high.
- Bubbles: a cycle with in_valid=0 inserts valid=0 and propagates. Data in invalid stages is don't-care, but must not raise out_valid.
- Output stability: while out_valid=1 and out_ready=0, out_taps and out_mode hold constant.
- done_cnt: increments on each edge with out_valid & out_ready. It saturates at 2^CNT_W-1 and does not wrap.
- Simultaneous accept and emit in the same cycle is legal, with no loss or duplication.
- STAGES=1 degenerates to a single registered gate with the same handshake.

Test Plan:
- Reset then idle: assert rst for 2 cycles with in_valid=1 -> out_valid=0, done_cnt=0, in_ready=1 after release; nothing emitted.
- NOR single item (STAGES=3, WIDTH=1, out_ready=1): a=0, b={d,c,b}=3'b000, mode=0 -> after 3 cycles out_taps={g,f,e}=3'b101, out_valid high exactly 1 cycle, done_cnt=1.
- NOR second vector: a=1, in_b=3'b010 (b=0, c=1, d=0) -> e=0, f=0, g=1; out_taps=3'b100. NAND mode: a=1, in_b=3'b111, mode=1 -> out_taps=3'b010, out_mode=1.
- Back-to-back streaming: 8 random items on consecutive cycles, out_ready=1 -> results in order, one per cycle, each matching the golden gate chain; done_cnt=8.
- Backpressure: stream items while out_ready toggles 1,0,0,1,... -> in_ready tracks ~out_valid|out_ready each cycle; out_taps stable while stalled; no loss or duplication; order preserved.
- Mid-flight reset plus saturation:
  - rst asserted with 2 items in the pipe -> out_valid=0 next cycle, and neither item ever appears.
  - With CNT_W=2, emit 5 results -> done_cnt=3.
